// File: rtl/pipe_scroller.sv
// Flappy Bird obstacle engine: game-tick divider, leftward-scrolling pipes with
// pseudo-random gap heights on re-entry, pass scoring and the redraw handshake.
module pipe_scroller #(
    parameter int NUM_PIPES = 2,
    parameter int SCREEN_W  = 640,
    parameter int STEP      = 1,
    parameter int TICK_DIV  = 1048576,
    parameter int Y_MIN     = 120,
    parameter int Y_BITS    = 8,
    parameter int SCORE_W   = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [10:0]             bird_x,
    input  logic                    frame_done,
    output logic [11*NUM_PIPES-1:0] pipe_x,
    output logic [11*NUM_PIPES-1:0] pipe_y,
    output logic                    tick,
    output logic                    frame_req,
    output logic [SCORE_W-1:0]      score,
    output logic                    score_pulse,
    output logic                    overrun
);
    localparam int CNT_W = $clog2(TICK_DIV);
    localparam int HIT_W = $clog2(NUM_PIPES + 1);
    localparam int SUM_W = ((SCORE_W > HIT_W) ? SCORE_W : HIT_W) + 1;

    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(TICK_DIV - 1);
    localparam logic [10:0]        X_LAST    = 11'(SCREEN_W - 1);
    localparam logic [10:0]        X_STEP    = 11'(STEP);
    localparam logic [10:0]        Y_BASE    = 11'(Y_MIN);
    localparam logic [15:0]        Y_MASK    = 16'((32'd1 << Y_BITS) - 32'd1);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    typedef enum logic {
        IDLE,
        REQ
    } state_t;

    logic [1:0]         rst_sync;
    logic               rst_i;
    logic [CNT_W-1:0]   cnt;
    logic [15:0]        lfsr;
    logic               wrap;
    logic [10:0]        px    [NUM_PIPES];
    logic [10:0]        py    [NUM_PIPES];
    logic [10:0]        x_nxt [NUM_PIPES];
    logic [10:0]        y_nxt [NUM_PIPES];
    logic [HIT_W-1:0]   hits;
    logic [SUM_W-1:0]   score_sum;
    logic [SCORE_W-1:0] score_nxt;
    state_t             state;

    // Reset asserts immediately through the async set, releases two edges later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rst_sync <= '1;
        end else begin
            rst_sync <= {rst_sync[0], 1'b0};
        end
    end

    assign rst_i = rst_sync[1];
    assign wrap  = enable && (cnt == CNT_LAST);

    always_comb begin
        hits = '0;
        for (int unsigned i = 0; i < NUM_PIPES; i++) begin
            x_nxt[i] = px[i];
            y_nxt[i] = py[i];
            if (px[i] < X_STEP) begin
                x_nxt[i] = X_LAST;
                y_nxt[i] = Y_BASE + 11'((lfsr ^ 16'(i)) & Y_MASK);
            end else begin
                x_nxt[i] = px[i] - X_STEP;
                if ((px[i] >= bird_x) && (x_nxt[i] < bird_x)) begin
                    hits = hits + HIT_W'(1);
                end
            end
        end
    end

    always_comb begin
        score_sum = SUM_W'(score) + SUM_W'(hits);
        score_nxt = (score_sum > SUM_W'(SCORE_MAX)) ? SCORE_MAX : SCORE_W'(score_sum);
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            cnt         <= '0;
            tick        <= 1'b0;
            lfsr        <= 16'hACE1;
            score       <= '0;
            score_pulse <= 1'b0;
            for (int unsigned i = 0; i < NUM_PIPES; i++) begin
                px[i] <= 11'((i + 1) * SCREEN_W / NUM_PIPES - 1);
                py[i] <= Y_BASE;
            end
        end else begin
            // Taps 16,14,13,11; free-running so gap heights follow player timing.
            lfsr        <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            tick        <= wrap;
            score_pulse <= wrap && (hits != '0);
            if (enable) begin
                cnt <= wrap ? '0 : cnt + CNT_W'(1);
            end
            if (wrap) begin
                score <= score_nxt;
                for (int unsigned i = 0; i < NUM_PIPES; i++) begin
                    px[i] <= x_nxt[i];
                    py[i] <= y_nxt[i];
                end
            end
        end
    end

    // A tick while a request is still pending wins over frame_done and flags overrun.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            frame_req <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (wrap) begin
                        state     <= REQ;
                        frame_req <= 1'b1;
                    end
                end
                REQ: begin
                    if (wrap) begin
                        overrun <= 1'b1;
                    end else if (frame_done) begin
                        state     <= IDLE;
                        frame_req <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    frame_req <= 1'b0;
                end
            endcase
        end
    end

    for (genvar g = 0; g < NUM_PIPES; g++) begin : g_pack
        assign pipe_x[11*g +: 11] = px[g];
        assign pipe_y[11*g +: 11] = py[g];
    end

endmodule

// File: tb/tb_pipe_scroller.sv
// Scoreboard bench for pipe_scroller: a cycle-level game model predicts every
// output per clock; a monitor pops predictions at each falling edge and compares.
module tb_pipe_scroller;
    localparam int TD   = 4;
    localparam int NP   = 2;
    localparam int SW   = 640;
    localparam int ST   = 1;
    localparam int YMIN = 120;
    localparam int YB   = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        frame_done;
    logic [10:0] bird_x;

    logic [21:0] pipe_x, pipe_y, s_pipe_x, s_pipe_y;
    logic        tick, frame_req, score_pulse, overrun;
    logic        s_tick, s_frame_req, s_score_pulse, s_overrun;
    logic [7:0]  score;
    logic [1:0]  s_score;

    pipe_scroller #(
        .NUM_PIPES(NP), .SCREEN_W(SW), .STEP(ST), .TICK_DIV(TD),
        .Y_MIN(YMIN), .Y_BITS(YB), .SCORE_W(8)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .bird_x(bird_x),
        .frame_done(frame_done), .pipe_x(pipe_x), .pipe_y(pipe_y),
        .tick(tick), .frame_req(frame_req), .score(score),
        .score_pulse(score_pulse), .overrun(overrun)
    );

    // Narrow score counter so saturation is reachable within a short run.
    pipe_scroller #(
        .NUM_PIPES(NP), .SCREEN_W(SW), .STEP(ST), .TICK_DIV(TD),
        .Y_MIN(YMIN), .Y_BITS(YB), .SCORE_W(2)
    ) dut_sat (
        .clk(clk), .reset(reset), .enable(enable), .bird_x(bird_x),
        .frame_done(frame_done), .pipe_x(s_pipe_x), .pipe_y(s_pipe_y),
        .tick(s_tick), .frame_req(s_frame_req), .score(s_score),
        .score_pulse(s_score_pulse), .overrun(s_overrun)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [21:0] px;
        logic [21:0] py;
        logic        tick;
        logic        req;
        logic        ovr;
        logic        pulse;
        logic [7:0]  score;
        logic [1:0]  score2;
    } exp_t;

    typedef struct {
        string name;
        int    sel;
        int    val;
    } dir_t;

    exp_t exp_q[$];
    dir_t dir_q[$];
    int   checks = 0;
    int   failures = 0;
    int   areq_n = 0;
    event areq;

    // Game model: whole-pixel positions, total pipes passed, pending-redraw flag.
    int          m_x[NP];
    int          m_y[NP];
    int          m_cnt, m_hold, m_total;
    bit          m_req, m_ovr, m_tick, m_pulse;
    logic [15:0] m_lfsr;

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[14:0], l[16-1] ^ l[14-1] ^ l[13-1] ^ l[11-1]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NP; i++) begin
            m_x[i] = (i + 1) * SW / NP - 1;
            m_y[i] = YMIN;
        end
        m_cnt = 0; m_total = 0; m_req = 0; m_ovr = 0;
        m_tick = 0; m_pulse = 0; m_lfsr = 16'hACE1; m_hold = 2;
    endtask

    task automatic model_edge();
        bit wrap;
        int n, old;
        if (reset) begin
            model_reset();
        end else if (m_hold > 0) begin
            m_hold--;
            m_tick = 0;
            m_pulse = 0;
        end else begin
            wrap = enable && (m_cnt + 1 == TD);
            if (enable) m_cnt = (m_cnt + 1) % TD;
            n = 0;
            if (wrap) begin
                for (int i = 0; i < NP; i++) begin
                    if (m_x[i] < ST) begin
                        m_x[i] = SW - 1;
                        m_y[i] = YMIN + int'((32'(m_lfsr) ^ i) & ((1 << YB) - 1));
                    end else begin
                        old = m_x[i];
                        m_x[i] = m_x[i] - ST;
                        if (old >= int'(bird_x) && m_x[i] < int'(bird_x)) n++;
                    end
                end
            end
            m_total += n;
            m_tick = wrap;
            m_pulse = wrap && (n > 0);
            if (m_req) begin
                if (wrap) m_ovr = 1;
                else if (frame_done) m_req = 0;
            end else if (wrap) begin
                m_req = 1;
            end
            m_lfsr = lfsr_next(m_lfsr);
        end
    endtask

    task automatic step();
        exp_t e;
        @(posedge clk);
        model_edge();
        for (int i = 0; i < NP; i++) begin
            e.px[11*i +: 11] = 11'(m_x[i]);
            e.py[11*i +: 11] = 11'(m_y[i]);
        end
        e.tick   = m_tick;
        e.req    = m_req;
        e.ovr    = m_ovr;
        e.pulse  = m_pulse;
        e.score  = 8'((m_total > 255) ? 255 : m_total);
        e.score2 = 2'((m_total > 3) ? 3 : m_total);
        exp_q.push_back(e);
        #2;
    endtask

    task automatic dir(input string name, input int sel, input int val);
        dir_t d;
        d.name = name;
        d.sel  = sel;
        d.val  = val;
        dir_q.push_back(d);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic logic [31:0] sig(input int sel);
        case (sel)
            0: return 32'(tick);
            1: return 32'(frame_req);
            2: return 32'(overrun);
            3: return 32'(score);
            4: return 32'(pipe_x[10:0]);
            5: return 32'(pipe_x[21:11]);
            6: return 32'(pipe_y[10:0]);
            7: return 32'(pipe_y[21:11]);
            default: return 32'(s_score);
        endcase
    endfunction

    // Monitor: one predicted record per falling edge, plus directed spot checks.
    initial begin
        exp_t e;
        dir_t d;
        int   areq_seen;
        areq_seen = 0;
        forever begin
            @(negedge clk or areq);
            if (areq_n != areq_seen) begin
                areq_seen = areq_n;
            end else if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                for (int i = 0; i < NP; i++) begin
                    chk($sformatf("pipe_x%0d", i), 32'(pipe_x[11*i +: 11]), 32'(e.px[11*i +: 11]));
                    chk($sformatf("pipe_y%0d", i), 32'(pipe_y[11*i +: 11]), 32'(e.py[11*i +: 11]));
                end
                chk("tick", 32'(tick), 32'(e.tick));
                chk("frame_req", 32'(frame_req), 32'(e.req));
                chk("overrun", 32'(overrun), 32'(e.ovr));
                chk("score", 32'(score), 32'(e.score));
                chk("score_pulse", 32'(score_pulse), 32'(e.pulse));
                chk("sat_score", 32'(s_score), 32'(e.score2));
                chk("sat_score_pulse", 32'(s_score_pulse), 32'(e.pulse));
                chk("sat_tick", 32'(s_tick), 32'(e.tick));
                chk("sat_frame_req", 32'(s_frame_req), 32'(e.req));
                chk("sat_overrun", 32'(s_overrun), 32'(e.ovr));
                chk("sat_pipe_x", 32'(s_pipe_x), 32'(e.px));
                chk("sat_pipe_y", 32'(s_pipe_y), 32'(e.py));
            end
            while (dir_q.size() > 0) begin
                d = dir_q.pop_front();
                chk(d.name, sig(d.sel), 32'(d.val));
            end
        end
    end

    initial begin
        reset = 1'b1;
        enable = 1'b0;
        frame_done = 1'b0;
        bird_x = 11'd300;
        repeat (3) step();
        dir("rst_x0", 4, 319); dir("rst_x1", 5, 639);
        dir("rst_y0", 6, 120); dir("rst_y1", 7, 120);
        dir("rst_score", 3, 0); dir("rst_frame_req", 1, 0);
        dir("rst_overrun", 2, 0); dir("rst_tick", 0, 0);

        reset = 1'b0;
        repeat (4) step();
        enable = 1'b1;
        repeat (3) step();
        dir("no_early_tick", 0, 0);
        step();
        dir("first_tick", 0, 1); dir("first_x0", 4, 318); dir("first_x1", 5, 638);
        dir("first_req", 1, 1); dir("first_overrun", 2, 0);

        repeat (4) step();
        dir("second_tick", 0, 1); dir("second_x0", 4, 317);
        dir("overrun_set", 2, 1); dir("req_held", 1, 1);
        frame_done = 1'b1;
        step();
        frame_done = 1'b0;
        dir("req_drop", 1, 0); dir("overrun_sticky", 2, 1);

        step();
        enable = 1'b0;
        repeat (10) step();
        dir("pause_no_tick", 0, 0); dir("pause_x0", 4, 317); dir("pause_x1", 5, 637);
        enable = 1'b1;
        step();
        dir("resume_wait", 0, 0);
        step();
        dir("resume_tick", 0, 1); dir("resume_x0", 4, 316); dir("resume_x1", 5, 636);

        repeat (7000) begin
            enable = ($urandom_range(0, 9) != 0);
            frame_done = ($urandom_range(0, 2) == 0);
            step();
        end

        enable = 1'b1;
        frame_done = 1'b0;
        for (int k = 0; k < 40 && frame_req !== 1'b1; k++) step();
        dir("wait_frame_req", 1, 1);
        #5;
        reset = 1'b1;
        #1;
        dir("async_req", 1, 0); dir("async_overrun", 2, 0); dir("async_score", 3, 0);
        dir("async_x0", 4, 319); dir("async_x1", 5, 639);
        dir("async_y0", 6, 120); dir("async_sat_score", 8, 0);
        areq_n++;
        -> areq;

        repeat (3) step();
        reset = 1'b0;
        bird_x = 11'($urandom_range(0, SW - 1));
        repeat (600) begin
            enable = ($urandom_range(0, 9) != 0);
            frame_done = ($urandom_range(0, 2) == 0);
            step();
        end

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_scroller.md
# pipe_scroller

Parametrised obstacle engine for the Flappy Bird game. Generates the game tick from the system clock, scrolls `NUM_PIPES` pipes leftward by `STEP` pixels per tick with independent wrap-around, and assigns each re-entering pipe a pseudo-random gap height. It also counts passed pipes as score and runs the once-per-tick redraw request handshake toward the display/clear logic. It sits between the top level and `Display_Manager`, replacing the ad-hoc pipe and clear-lock logic.

## Interface

Parameters:
- `NUM_PIPES`, 2, number of pipes (1–8)
- `SCREEN_W`, 640, horizontal extent; x range is 0..SCREEN_W-1
- `STEP`, 1, pixels moved per tick (1 ≤ STEP < SCREEN_W/NUM_PIPES)
- `TICK_DIV`, 1048576, clk cycles per game tick (≥ 2)
- `Y_MIN`, 120, minimum gap y
- `Y_BITS`, 8, random span; gap y = Y_MIN + (0..2^Y_BITS-1)
- `SCORE_W`, 8, score counter width

Ports:
- `clk`  in  1  system clock (50 MHz)
- `reset`  in  1  asynchronous, active-high
- `enable`  in  1  1 = run, 0 = pause scrolling
- `bird_x`  in  11  bird x coordinate, used for scoring
- `frame_done`  in  1  redraw-complete acknowledge from the display side
- `pipe_x`  out  11*NUM_PIPES  packed x; pipe i at bits [11i+10:11i]
- `pipe_y`  out  11*NUM_PIPES  packed gap y, same packing
- `tick`  out  1  one-cycle game-tick pulse
- `frame_req`  out  1  redraw request, level
- `score`  out  SCORE_W  pipes passed, saturating
- `score_pulse`  out  1  one-cycle pulse per score increment
- `overrun`  out  1  sticky flag: a tick arrived while frame_req was still pending

## Operation

- Reset values, applied asynchronously:
  - pipe_x[i] = (i+1)*SCREEN_W/NUM_PIPES - 1 (defaults: 319, 639)
  - pipe_y[i] = Y_MIN
  - tick = 0, frame_req = 0, score = 0, score_pulse = 0, overrun = 0
  - tick counter = 0, LFSR = 16'hACE1
- Tick divider:
  - Counter increments only while enable = 1. It holds its value while enable = 0.
  - When the counter equals TICK_DIV-1, it returns to 0 and `tick` pulses.
- LFSR:
  - 16-bit Fibonacci LFSR, taps 16, 14, 13, 11.
  - Advances every clk cycle regardless of enable, so gap heights depend on player timing.
- On a tick, all pipes update on the same edge:
  - If x < STEP: x ← SCREEN_W-1, and y ← Y_MIN + ((lfsr ^ i) & (2^Y_BITS-1)).
  - Otherwise: x ← x - STEP, and y is unchanged.
- Scoring:
  - Pipe i scores on a tick when old x ≥ bird_x and new x < bird_x, with no wrap on that tick.
  - Several pipes scoring on the same tick add their total count.
  - score saturates at 2^SCORE_W-1.
  - score_pulse fires on any tick with at least one score, including when score is saturated.
- Redraw FSM, two states:
  - IDLE: on tick → REQ; frame_req = 1.
  - REQ: if frame_done = 1 and no tick this cycle → IDLE; frame_req = 0.
  - REQ: if a tick arrives → stay in REQ and set overrun = 1. A tick has priority over a simultaneous frame_done.
  - frame_done is ignored in IDLE.
  - overrun is cleared only by reset.
- Positions are not frozen during REQ. A later tick updates them.

## Timing

- tick, the new pipe_x/pipe_y, score/score_pulse and the frame_req rise all appear on the same clock edge: the edge where the counter wraps.
- The first tick after reset release, with enable = 1, occurs on the TICK_DIV-th rising edge.
- Tick period is exactly TICK_DIV cycles of enabled time.
- frame_req falls on the edge after frame_done is sampled high in REQ (1-cycle latency).
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Async reset asserted at any point, including mid-REQ or mid-count, forces the reset values immediately. Release is synchronised internally.

## Test plan

Bench configuration: TICK_DIV=4, NUM_PIPES=2, SCREEN_W=640, STEP=1, Y_MIN=120, Y_BITS=8.

1. Reset, then enable = 1 → outputs x = 319/639, y = 120/120, score = 0; first tick on the 4th edge gives x = 318/638. Ticks repeat every 4 cycles.
2. Run 319 ticks (pipe0 x = 0), then one more → pipe0 x = 639, pipe0 y in 120..375, pipe1 x = 319, pipe1 y unchanged.
3. Hold frame_done = 0 across two ticks → frame_req stays 1 and overrun = 1 after the second tick. Pulse frame_done → frame_req = 0 one cycle later; overrun stays 1.
4. bird_x = 300: pipe0 moves from 300 to 299 → score = 1 and score_pulse high for exactly one cycle. Preload score = 255 → score stays 255 and the pulse still fires.
5. enable = 0 for 10 cycles mid-count → no tick, and counter and positions hold. On re-enable, the tick lands after the remaining count.
6. Assert reset asynchronously between clock edges while in REQ → frame_req, overrun and score go to 0 and positions return to 319/639 without waiting for a clk edge.
